// File: rtl/mandel_worker.sv
// mandel_worker: pixel-job responder that runs a fixed-point Mandelbrot escape-time test
// and returns a palette colour with the job coordinates, holding pixel_done as a level.
module mandel_worker #(
    parameter int WIDTH    = 1280,
    parameter int HEIGHT   = 720,
    parameter int MAX_ITER = 64,
    parameter int FRAC     = 12,
    parameter int DW       = 32,
    parameter int STEP     = 10,
    localparam int XW      = $clog2(WIDTH),
    localparam int YW      = $clog2(HEIGHT)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start_in,
    input  logic [XW-1:0] curr_x,
    input  logic [YW-1:0] curr_y,
    input  logic [31:0]   timer,
    output logic          pixel_done,
    output logic [23:0]   color_out,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y
);
    typedef enum logic [2:0] {BOOT, DONE, SETUP, ITER, SHADE} state_t;
    state_t state;
    logic [XW-1:0] job_x;
    logic [YW-1:0] job_y;
    logic [7:0] job_t, iter, idx;
    logic signed [DW-1:0] c_re, c_im, zr, zi;
    logic signed [2*DW-1:0] zr_e, zi_e, zr2, zi2, zri, nzr, nzi;
    logic escape;
    logic unused_timer;
    assign unused_timer = ^timer[31:8];
    // Full-width products keep the escape compare free of overflow.
    always_comb begin
        zr_e = {{DW{zr[DW-1]}}, zr};
        zi_e = {{DW{zi[DW-1]}}, zi};
        zr2 = (zr_e * zr_e) >>> FRAC;
        zi2 = (zi_e * zi_e) >>> FRAC;
        zri = (zr_e * zi_e) >>> FRAC;
        nzr = zr2 - zi2 + {{DW{c_re[DW-1]}}, c_re};
        nzi = (zri <<< 1) + {{DW{c_im[DW-1]}}, c_im};
        escape = (zr2 + zi2 > ((2*DW)'(4) <<< FRAC)) || iter == 8'(MAX_ITER);
        idx = iter + job_t;
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= BOOT;
            pixel_done <= 1'b0;
            color_out <= '0;
            out_x <= '0;
            out_y <= '0;
            iter <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= DONE;
                    pixel_done <= 1'b1;
                end
                DONE: if (start_in) begin
                    job_x <= curr_x;
                    job_y <= curr_y;
                    job_t <= timer[7:0];
                    pixel_done <= 1'b0;
                    state <= SETUP;
                end
                SETUP: begin
                    c_re <= ($signed({{(DW-XW){1'b0}}, job_x}) - DW'(WIDTH/2)) * DW'(STEP);
                    c_im <= ($signed({{(DW-YW){1'b0}}, job_y}) - DW'(HEIGHT/2)) * DW'(STEP);
                    zr <= '0;
                    zi <= '0;
                    iter <= '0;
                    state <= ITER;
                end
                ITER: if (escape) begin
                    state <= SHADE;
                end else begin
                    zr <= nzr[DW-1:0];
                    zi <= nzi[DW-1:0];
                    iter <= iter + 8'd1;
                end
                SHADE: begin
                    color_out <= (iter == 8'(MAX_ITER)) ? 24'h0 : {idx, idx[6:0], 1'b0, 8'hFF - idx};
                    out_x <= job_x;
                    out_y <= job_y;
                    pixel_done <= 1'b1;
                    state <= DONE;
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: doc/mandel_worker.md
Name: mandel_worker

Overview:
- Responder end of the renderer's pixel-job handshake; a drop-in peer of the raymarcher port set (start_in, curr_x, curr_y, timer in; pixel_done, color_out, out_x, out_y out).
- Accepts one pixel job and iterates z = z² + c in signed fixed point (Mandelbrot escape-time test).
- Returns a palette colour and the job's coordinates for the frame-buffer write.
- Holds pixel_done as a level until the initiator issues the next job, so multiple workers behind one dispatcher never lose a completion.

Parameters:
- WIDTH, 1280, horizontal pixel count.
- HEIGHT, 720, vertical pixel count.
- MAX_ITER, 64, iteration cap (≤255).
- FRAC, 12, fraction bits of the fixed-point format.
- DW, 32, signed datapath width.
- STEP, 10, complex-plane step per pixel in fixed point (10/4096 ≈ 0.00244).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; synchronous, active-high.
- start_in  input  1  job strobe; sampled only in DONE.
- curr_x  input  $clog2(WIDTH)  job pixel x.
- curr_y  input  $clog2(HEIGHT)  job pixel y.
- timer  input  32  frame counter; only bits [7:0] are used, for palette rotation.
- pixel_done  output  1  result valid / ready for a job; level.
- color_out  output  24  {R,G,B} result.
- out_x  output  $clog2(WIDTH)  x of the result.
- out_y  output  $clog2(HEIGHT)  y of the result.

Behaviour:
- Reset: clock is clk_in; reset is rst_in, synchronous and active-high.
  - While rst_in is high: state=BOOT, pixel_done=0, color_out=0, out_x=0, out_y=0, iter=0.
  - Reset mid-job abandons the job; no result is emitted.
- States: BOOT, DONE, SETUP, ITER, SHADE.
- BOOT: one cycle, then → DONE with pixel_done<=1. The bootstrap completion (0,0,colour 0) lets the dispatcher issue the first job.
- DONE:
  - pixel_done, color_out, out_x and out_y are held stable.
  - start_in=1 at cycle T: latch curr_x/curr_y/timer[7:0] into job registers, pixel_done<=0, → SETUP.
  - start_in=0: stay.
- SETUP (T+1):
  - c_re = (x − WIDTH/2)·STEP, c_im = (y − HEIGHT/2)·STEP, computed signed in DW bits.
  - zr=zi=0, iter=0; → ITER.
- ITER, one cycle each:
  - Form zr2 = (zr·zr)>>>FRAC, zi2 = (zi·zi)>>>FRAC, zri = (zr·zi)>>>FRAC. Products are 2·DW bits; the shift is arithmetic and truncates toward −∞.
  - If zr2+zi2 > (4<<FRAC) strictly, or iter==MAX_ITER: → SHADE; z and iter are not updated.
  - Else: zr<=zr2−zi2+c_re, zi<=2·zri+c_im, iter<=iter+1.
- SHADE, one cycle:
  - iter==MAX_ITER without escape: colour=0.
  - Otherwise idx = iter[7:0] + timer_latched (mod 256); colour = {idx, idx<<1 (mod 256), 255−idx}.
  - Register color_out, out_x=job x, out_y=job y; pixel_done<=1; → DONE.
- Latency: ITER occupies iter_final+1 cycles, so pixel_done rises at T+4+iter_final. Minimum T+4; maximum T+4+MAX_ITER.
- pixel_done never pulses; it falls exactly one cycle after an accepted start_in.
- start_in in BOOT/SETUP/ITER/SHADE: ignored; no queuing.
- start_in held for several cycles: only the DONE-cycle sample is accepted; it is not re-accepted until the next DONE.
- Coordinates are unsigned; the centre offset is computed in signed arithmetic with no wrap. WIDTH/2 and HEIGHT/2 are integer halves.
- Outputs depend only on registers (no combinational input→output paths).

Test Plan:
- Reset 5 cycles, release → pixel_done=0 during reset, 1 from the first post-reset cycle, color_out=0, out=(0,0); stays high with start_in=0.
- Start (640,360), timer=0 (c=0) → no escape; pixel_done low T+1..T+67, high at T+68; color_out=0x000000, out=(640,360).
- Start (1279,360), timer=0 (c_re=6390) → z1=6390, z2=16358, escape with iter=2; pixel_done high at T+6; color_out=0x0204FD, out=(1279,360).
- Same job with timer=0x000000FE → idx=0x00; color_out=0x0000FF at T+6.
- start_in pulsed at T+2 and T+3 during a job → ignored; the result is unchanged; the next start in DONE is accepted normally.
- rst_in asserted at T+10 of the centre-pixel job → no result for (640,360); BOOT→DONE bootstrap (0,0,0) repeats; a new job then completes normally.
